// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration of one SPI bus between two master engines,
// with a chip-select idle gap between owners and a tenure watchdog.
module spi_bus_arbiter #(
   parameter int unsigned GAP_CYCLES     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic        SCLK_IDLE      = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   input  logic [1:0] c_sclk,
   input  logic [1:0] c_mosi,
   input  logic [1:0] c_cs_n,
   output logic [1:0] c_miso,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs_0,
   output logic       spi_cs_1,
   input  logic       spi_miso,
   output logic [1:0] owner,
   output logic [1:0] timeout_evt
);

   localparam int unsigned GAP_W = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
   localparam int unsigned TEN_W = $clog2((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_MAX  = '1;
   localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [TEN_W-1:0] TEN_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [1:0]       lockout_q, lockout_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TEN_W-1:0] ten_q, ten_d;
   logic [1:0]       gnt_d, owner_d, evt_d;
   logic [1:0]       elig;
   logic             idx;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         lockout_q   <= 2'b00;
         gap_q       <= '0;
         ten_q       <= '0;
         gnt         <= 2'b00;
         owner       <= 2'b00;
         timeout_evt <= 2'b00;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         lockout_q   <= lockout_d;
         gap_q       <= gap_d;
         ten_q       <= ten_d;
         gnt         <= gnt_d;
         owner       <= owner_d;
         timeout_evt <= evt_d;
      end
   end

   // Next-state, grant and watchdog decisions
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      lockout_d = lockout_q & req;
      gap_d     = gap_q;
      ten_d     = ten_q;
      gnt_d     = 2'b00;
      owner_d   = 2'b00;
      evt_d     = 2'b00;
      elig      = req & ~lockout_q;
      idx       = (state_q == OWN1);

      case (state_q)
         IDLE: begin
            gap_d = '0;
            ten_d = '0;
            if (elig[0] && (!elig[1] || last_q)) begin
               state_d = OWN0;
               gnt_d   = 2'b01;
               owner_d = 2'b01;
               last_d  = 1'b0;
            end else if (elig[1]) begin
               state_d = OWN1;
               gnt_d   = 2'b10;
               owner_d = 2'b10;
               last_d  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            gap_d = '0;
            // A release on the watchdog's last cycle wins over the timeout
            if (!req[idx]) begin
               state_d = GAP;
            end else if ((TIMEOUT_CYCLES != 0) && (ten_q == TEN_LAST)) begin
               state_d        = GAP;
               evt_d[idx]     = 1'b1;
               lockout_d[idx] = 1'b1;
            end else begin
               gnt_d[idx]   = 1'b1;
               owner_d[idx] = 1'b1;
               if ((TIMEOUT_CYCLES != 0) && (ten_q != TEN_MAX)) begin
                  ten_d = ten_q + 1'b1;
               end
            end
         end
         GAP: begin
            ten_d = '0;
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else if (gap_q != GAP_MAX) begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus fan-in/fan-out follows the registered owner with no added latency
   always_comb begin
      spi_cs_0 = 1'b1;
      spi_cs_1 = 1'b1;
      spi_sclk = SCLK_IDLE;
      spi_mosi = 1'b0;
      c_miso   = 2'b00;
      if (!rst) begin
         case (state_q)
            OWN0: begin
               spi_cs_0  = c_cs_n[0];
               spi_sclk  = c_sclk[0];
               spi_mosi  = c_mosi[0];
               c_miso[0] = spi_miso;
            end
            OWN1: begin
               spi_cs_1  = c_cs_n[1];
               spi_sclk  = c_sclk[1];
               spi_mosi  = c_mosi[1];
               c_miso[1] = spi_miso;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed vector table, a randomized
// run against a cycle-level reference model, and watchdog/fairness sequences.
module tb_spi_bus_arbiter;

   localparam int unsigned GAP = 8;
   localparam int unsigned TO  = 16;

   logic       clk;
   logic       rst, spi_miso;
   logic [1:0] req, c_sclk, c_mosi, c_cs_n;
   logic [1:0] gnt, c_miso, owner, timeout_evt;
   logic       spi_sclk, spi_mosi, spi_cs_0, spi_cs_1;

   logic       b_rst, b_spi_miso;
   logic [1:0] b_req, b_c_sclk, b_c_mosi, b_c_cs_n;
   logic [1:0] b_gnt, b_c_miso, b_owner, b_timeout_evt;
   logic       b_spi_sclk, b_spi_mosi, b_spi_cs_0, b_spi_cs_1;

   int vectors = 0;
   int miscompares = 0;

   int hi, ev, ev2, got, n, held, zrun, overlap, bad, bev;
   logic [1:0] g, prev;

   spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .SCLK_IDLE(1'b0)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .c_sclk(c_sclk), .c_mosi(c_mosi), .c_cs_n(c_cs_n), .c_miso(c_miso),
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_0(spi_cs_0), .spi_cs_1(spi_cs_1),
      .spi_miso(spi_miso), .owner(owner), .timeout_evt(timeout_evt)
   );

   spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(0), .SCLK_IDLE(1'b0)) dut_b (
      .clk(clk), .rst(b_rst), .req(b_req), .gnt(b_gnt),
      .c_sclk(b_c_sclk), .c_mosi(b_c_mosi), .c_cs_n(b_c_cs_n), .c_miso(b_c_miso),
      .spi_sclk(b_spi_sclk), .spi_mosi(b_spi_mosi), .spi_cs_0(b_spi_cs_0), .spi_cs_1(b_spi_cs_1),
      .spi_miso(b_spi_miso), .owner(b_owner), .timeout_evt(b_timeout_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle: {gnt, owner, cs1, cs0, sclk, mosi, c_miso, timeout_evt}
   typedef struct packed {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  cs_n;
      logic [1:0]  sclk;
      logic [1:0]  mosi;
      logic        miso;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] csn,
                               input logic [1:0] sc, input logic [1:0] mo, input logic mi,
                               input logic [1:0] eg, input logic [1:0] ecs, input logic esc,
                               input logic emo, input logic [1:0] ecm, input logic [1:0] eev);
      vec_t v;
      v.rst  = r;
      v.req  = rq;
      v.cs_n = csn;
      v.sclk = sc;
      v.mosi = mo;
      v.miso = mi;
      v.exp  = {eg, eg, ecs, esc, emo, ecm, eev};
      return v;
   endfunction

   function automatic logic [11:0] pack_a();
      return {gnt, owner, spi_cs_1, spi_cs_0, spi_sclk, spi_mosi, c_miso, timeout_evt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner index, remaining gap cycles, elapsed tenure
   int         m_own;
   int         m_ten;
   int         m_gap;
   int         m_last;
   logic [1:0] m_lock;
   logic [1:0] m_evt;

   task automatic model_reset();
      m_own  = -1;
      m_ten  = 0;
      m_gap  = 0;
      m_last = 1;
      m_lock = 2'b00;
      m_evt  = 2'b00;
   endtask

   function automatic logic [11:0] model_out();
      logic [1:0] eg, ecs, ecm;
      logic       esc, emo;
      eg  = 2'b00;
      ecs = 2'b11;
      ecm = 2'b00;
      esc = 1'b0;
      emo = 1'b0;
      if (m_own == 0) eg = 2'b01;
      if (m_own == 1) eg = 2'b10;
      if (!rst && m_own == 0) begin
         ecs[0] = c_cs_n[0]; esc = c_sclk[0]; emo = c_mosi[0]; ecm[0] = spi_miso;
      end
      if (!rst && m_own == 1) begin
         ecs[1] = c_cs_n[1]; esc = c_sclk[1]; emo = c_mosi[1]; ecm[1] = spi_miso;
      end
      return {eg, eg, ecs, esc, emo, ecm, m_evt};
   endfunction

   task automatic model_step();
      logic [1:0] elig;
      if (rst) begin
         model_reset();
         return;
      end
      elig   = req & ~m_lock;
      m_evt  = 2'b00;
      m_lock = m_lock & req;
      if (m_own >= 0) begin
         if (!req[m_own]) begin
            m_own = -1;
            m_gap = GAP;
         end else if (TO != 0 && m_ten == TO - 1) begin
            m_evt[m_own]  = 1'b1;
            m_lock[m_own] = 1'b1;
            m_own = -1;
            m_gap = GAP;
         end else begin
            m_ten++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (elig != 2'b00) begin
         if (elig == 2'b11) m_own = 1 - m_last;
         else               m_own = elig[0] ? 0 : 1;
         m_last = m_own;
         m_ten  = 0;
      end
   endtask

   task automatic reset_a();
      @(negedge clk);
      rst    = 1'b1;
      req    = 2'b00;
      c_cs_n = 2'b11;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; c_sclk = 2'b00; c_mosi = 2'b00; c_cs_n = 2'b11; spi_miso = 1'b0;
      b_rst = 1'b1; b_req = 2'b00; b_c_sclk = 2'b00; b_c_mosi = 2'b00; b_c_cs_n = 2'b11;
      b_spi_miso = 1'b0;

      // rst, req, cs_n, sclk, mosi, miso | gnt, {cs1,cs0}, sclk, mosi, c_miso, evt
      tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b01, 2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b01, 2'b10, 2'b01, 2'b01, 1, 2'b01, 2'b10, 1, 1, 2'b01, 2'b00));
      tbl.push_back(mk(0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 2'b01, 2'b10, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 2'b01, 2'b10, 2'b01, 2'b01, 1, 2'b01, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b00, 2'b10, 2'b01, 2'b01, 1, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b10, 1, 1, 2'b01, 2'b00));
      tbl.push_back(mk(0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2'b01, 2'b11, 0, 0, 2'b01, 2'b00));
      for (int k = 0; k < 9; k++)
         tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 2'b11, 1, 2'b10, 2'b01, 1, 1, 2'b10, 2'b00));
      tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 2'b10, 2'b11, 0, 0, 2'b00, 2'b00));

      repeat (2) @(posedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; req = tbl[i].req; c_cs_n = tbl[i].cs_n;
         c_sclk = tbl[i].sclk; c_mosi = tbl[i].mosi; spi_miso = tbl[i].miso;
         #1;
         check($sformatf("table[%0d]", i), 32'(pack_a()), 32'(tbl[i].exp));
      end

      // Randomized traffic against the reference model
      reset_a();
      model_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(499, 0) == 0);
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               if ($urandom_range(11, 0) == 0) req[i] = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
               req[i] = 1'b1;
            end
         end
         c_sclk   = 2'($urandom);
         c_mosi   = 2'($urandom);
         c_cs_n   = 2'($urandom);
         spi_miso = 1'($urandom);
         #1;
         check("random", 32'(pack_a()), 32'(model_out()));
         model_step();
      end

      // Round-robin over six tenures with both clients always re-requesting
      reset_a();
      req = 2'b11;
      n = 0; held = 0; zrun = 0; overlap = 0; prev = 2'b00;
      for (int k = 0; k < 400 && n < 6; k++) begin
         @(negedge clk);
         #1;
         g = gnt;
         if (g == 2'b11) overlap++;
         if (g != 2'b00 && prev == 2'b00) begin
            check($sformatf("rr_order[%0d]", n), 32'(g), (n % 2 == 0) ? 32'd1 : 32'd2);
            if (n > 0) check($sformatf("rr_gap[%0d]", n), 32'(zrun), 32'(GAP + 1));
            n++;
            held = 0;
            zrun = 0;
         end
         if (g == 2'b00) zrun++;
         req = 2'b11;
         if (g != 2'b00) begin
            if (held >= 3) req = ~g;
            held++;
         end
         prev = g;
      end
      check("rr_tenures", 32'(n), 32'd6);
      check("rr_overlap", 32'(overlap), 32'd0);

      // Watchdog: client 1 holds its request past the tenure limit
      reset_a();
      req = 2'b10;
      c_cs_n = 2'b00;
      hi = 0; ev = 0;
      repeat (60) begin
         @(negedge clk);
         #1;
         if (gnt[1]) hi++;
         if (timeout_evt != 2'b00) begin
            ev++;
            check("wd_evt_value", 32'(timeout_evt), 32'(2'b10));
            check("wd_cs1_forced_high", 32'(spi_cs_1), 32'd1);
            check("wd_gnt_cleared", 32'(gnt), 32'(2'b00));
         end
      end
      check("wd_grant_cycles", 32'(hi), 32'd16);
      check("wd_evt_pulses", 32'(ev), 32'd1);

      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      req = 2'b10;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         @(negedge clk);
         #1;
         if (gnt[1]) got = 1;
      end
      check("wd_regrant_after_toggle", 32'(got), 32'd1);

      // Release on the final watchdog cycle is a normal release
      if (got != 0) begin
         repeat (15) @(negedge clk);
         req = 2'b00;
         ev2 = 0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (k == 0) check("rel_vs_timeout_gnt", 32'(gnt), 32'(2'b00));
            if (timeout_evt != 2'b00) ev2++;
         end
         check("rel_vs_timeout_evt", 32'(ev2), 32'd0);
      end

      // Watchdog disabled: a 10000-cycle tenure is never revoked
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      b_req = 2'b01;
      bad = 0; bev = 0;
      repeat (10000) begin
         @(negedge clk);
         #1;
         if (b_gnt != 2'b01) bad++;
         if (b_timeout_evt != 2'b00) bev++;
      end
      check("to0_gnt_held", 32'(bad), 32'd0);
      check("to0_no_evt", 32'(bev), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
